execute_stage_unit: RTL and testbench

- RV32I execute stage: decodes the ALU operation from the main-decoder class (EX_ALUOp_i) plus funct3/funct7[5], then computes the ALU result and a zero flag.
- Sits between the ID/EX pipeline register and the EX/MEM register.
- Operands are already muxed (forwarding and immediate selection happen upstream).
- Result and zero flag are registered with one-cycle latency.

---
 rtl/execute_stage_unit.sv | 142 ++++++++++++++
 tb/tb_execute_stage_unit.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage_unit.sv
// rtl/execute_stage_unit.sv - RV32I execute stage: ALU control decode, ALU, registered result and zero flag
// Optional build macro: EX_ALU_OVERFLOW_EN adds the registered EX_alu_overflow_o port.

package execute_stage_pkg;
  parameter int DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    ALUOP_NONE        = 3'd0,
    ALUOP_MEM_ADDR    = 3'd1,
    ALUOP_BRANCH      = 3'd2,
    ALUOP_LUI         = 3'd3,
    ALUOP_JUMP        = 3'd4,
    ALUOP_RTYPE       = 3'd5,
    ALUOP_ITYPE_ARITH = 3'd6
  } alu_op_e;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10,
    ALU_ZERO   = 4'd11
  } alu_fn_e;
endpackage

module execute_stage_unit
  import execute_stage_pkg::*;
#(
  parameter int DATA_WIDTH = execute_stage_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] EX_alu_operand1_i,
  input  logic [DATA_WIDTH-1:0] EX_alu_operand2_i,
  input  logic [2:0]            EX_alu_ctrl_funct3_i,
  input  logic                  EX_alu_ctrl_funct7_i,
  input  alu_op_e               EX_ALUOp_i,
  output logic [DATA_WIDTH-1:0] EX_alu_result_o,
  output logic                  EX_alu_zeroFlag_o
`ifdef EX_ALU_OVERFLOW_EN
  ,
  output logic                  EX_alu_overflow_o
`endif
);

  alu_fn_e               alu_fn;
  logic [DATA_WIDTH-1:0] result_next;
  logic [4:0]            shamt;

  assign shamt = EX_alu_operand2_i[4:0];

  // ALU control: the operation class is decoded first so that funct fields
  // are only consulted for R/I-type and can never leak X into other classes.
  always_comb begin
    alu_fn = ALU_ZERO;
    case (EX_ALUOp_i)
      ALUOP_MEM_ADDR,
      ALUOP_JUMP:     alu_fn = ALU_ADD;
      ALUOP_BRANCH:   alu_fn = ALU_SUB;
      ALUOP_LUI:      alu_fn = ALU_PASS_B;
      ALUOP_RTYPE,
      ALUOP_ITYPE_ARITH: begin
        case (EX_alu_ctrl_funct3_i)
          3'b000: alu_fn = (EX_ALUOp_i == ALUOP_RTYPE && EX_alu_ctrl_funct7_i)
                           ? ALU_SUB : ALU_ADD;
          3'b001: alu_fn = ALU_SLL;
          3'b010: alu_fn = ALU_SLT;
          3'b011: alu_fn = ALU_SLTU;
          3'b100: alu_fn = ALU_XOR;
          3'b101: alu_fn = EX_alu_ctrl_funct7_i ? ALU_SRA : ALU_SRL;
          3'b110: alu_fn = ALU_OR;
          3'b111: alu_fn = ALU_AND;
          default: alu_fn = ALU_ZERO;
        endcase
      end
      default:        alu_fn = ALU_ZERO;
    endcase
  end

  // ALU datapath: one result per selected function, zero for NONE/illegal.
  always_comb begin
    result_next = '0;
    case (alu_fn)
      ALU_ADD:    result_next = EX_alu_operand1_i + EX_alu_operand2_i;
      ALU_SUB:    result_next = EX_alu_operand1_i - EX_alu_operand2_i;
      ALU_SLL:    result_next = EX_alu_operand1_i << shamt;
      ALU_SLT:    result_next = {{(DATA_WIDTH-1){1'b0}},
                                 ($signed(EX_alu_operand1_i) < $signed(EX_alu_operand2_i))};
      ALU_SLTU:   result_next = {{(DATA_WIDTH-1){1'b0}},
                                 (EX_alu_operand1_i < EX_alu_operand2_i)};
      ALU_XOR:    result_next = EX_alu_operand1_i ^ EX_alu_operand2_i;
      ALU_SRL:    result_next = EX_alu_operand1_i >> shamt;
      ALU_SRA:    result_next = $unsigned($signed(EX_alu_operand1_i) >>> shamt);
      ALU_OR:     result_next = EX_alu_operand1_i | EX_alu_operand2_i;
      ALU_AND:    result_next = EX_alu_operand1_i & EX_alu_operand2_i;
      ALU_PASS_B: result_next = EX_alu_operand2_i;
      default:    result_next = '0;
    endcase
  end

`ifdef EX_ALU_OVERFLOW_EN
  logic overflow_next;

  // Signed overflow: ADD when like-signed operands give an opposite-signed
  // sum; SUB when unlike-signed operands give a result whose sign left op A.
  always_comb begin
    overflow_next = 1'b0;
    case (alu_fn)
      ALU_ADD: overflow_next = (EX_alu_operand1_i[DATA_WIDTH-1] == EX_alu_operand2_i[DATA_WIDTH-1]) &&
                               (result_next[DATA_WIDTH-1] != EX_alu_operand1_i[DATA_WIDTH-1]);
      ALU_SUB: overflow_next = (EX_alu_operand1_i[DATA_WIDTH-1] != EX_alu_operand2_i[DATA_WIDTH-1]) &&
                               (result_next[DATA_WIDTH-1] != EX_alu_operand1_i[DATA_WIDTH-1]);
      default: overflow_next = 1'b0;
    endcase
  end
`endif

  // EX/MEM-facing output register: result and its zero flag move together.
  always_ff @(posedge clk) begin
    if (rst) begin
      EX_alu_result_o   <= '0;
      EX_alu_zeroFlag_o <= 1'b1;
`ifdef EX_ALU_OVERFLOW_EN
      EX_alu_overflow_o <= 1'b0;
`endif
    end else begin
      EX_alu_result_o   <= result_next;
      EX_alu_zeroFlag_o <= (result_next == '0);
`ifdef EX_ALU_OVERFLOW_EN
      EX_alu_overflow_o <= overflow_next;
`endif
    end
  end

endmodule

// File: tb/tb_execute_stage_unit.sv
// tb/tb_execute_stage_unit.sv - self-checking bench for execute_stage_unit with a behavioural ALU model
module tb_execute_stage_unit;
  import execute_stage_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [2:0]  f3;
  logic        f7;
  alu_op_e     aluop;
  logic [31:0] res;
  logic        zf;
`ifdef EX_ALU_OVERFLOW_EN
  logic        ovf;
`endif

  int compared = 0;
  int mismatched = 0;

  execute_stage_unit #(.DATA_WIDTH(32)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .EX_alu_operand1_i    (op1),
    .EX_alu_operand2_i    (op2),
    .EX_alu_ctrl_funct3_i (f3),
    .EX_alu_ctrl_funct7_i (f7),
    .EX_ALUOp_i           (aluop),
    .EX_alu_result_o      (res),
    .EX_alu_zeroFlag_o    (zf)
`ifdef EX_ALU_OVERFLOW_EN
    ,
    .EX_alu_overflow_o    (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    alu_op_e     op;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  // Reference: which arithmetic the instruction asks for, as a small code
  // 0 none, 1 add, 2 sub, 3 sll, 4 slt, 5 sltu, 6 xor, 7 srl, 8 sra, 9 or, 10 and, 11 pass b
  function automatic int ref_kind(input logic [2:0] op, input logic [2:0] fn3, input logic fn7);
    if (op == 3'd1 || op == 3'd4) return 1;
    if (op == 3'd2) return 2;
    if (op == 3'd3) return 11;
    if (op == 3'd5 || op == 3'd6) begin
      if (fn3 == 3'd0) return (op == 3'd5 && fn7 == 1'b1) ? 2 : 1;
      if (fn3 == 3'd1) return 3;
      if (fn3 == 3'd2) return 4;
      if (fn3 == 3'd3) return 5;
      if (fn3 == 3'd4) return 6;
      if (fn3 == 3'd5) return (fn7 == 1'b1) ? 8 : 7;
      if (fn3 == 3'd6) return 9;
      return 10;
    end
    return 0;
  endfunction

  function automatic logic [31:0] ref_result(input int k, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    int unsigned sh = int'(b % 32);
    case (k)
      1:  return 32'((longint'(a) + longint'(b)) % 64'h1_0000_0000);
      2:  return 32'((64'h1_0000_0000 + longint'(a) - longint'(b)) % 64'h1_0000_0000);
      3:  return 32'((longint'(a) * (64'd1 << sh)) % 64'h1_0000_0000);
      4:  return (sa < sb) ? 32'd1 : 32'd0;
      5:  return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
      6:  return a ^ b;
      7:  return 32'(longint'(a) / (64'd1 << sh));
      8:  return a[31] ? ~((~a) >> sh) : (a >> sh);
      9:  return a | b;
      10: return a & b;
      11: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_overflow(input int k, input logic [31:0] a, input logic [31:0] b);
    longint s;
    if (k == 1) s = longint'($signed(a)) + longint'($signed(b));
    else if (k == 2) s = longint'($signed(a)) - longint'($signed(b));
    else return 1'b0;
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  task automatic drive(input alu_op_e o, input logic [2:0] x3, input logic x7,
                       input logic [31:0] a, input logic [31:0] b);
    aluop = o; f3 = x3; f7 = x7; op1 = a; op2 = b;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(ALUOP_MEM_ADDR, 3'd0, 1'b0, 32'd7, 32'd9);
    repeat (2) @(posedge clk);
    #1;
    compared++;
    if (res !== 32'd0 || zf !== 1'b1) begin
      $display("FAIL reset_state: result=%h zero=%b, required result=0 zero=1", res, zf);
      mismatched++;
    end
`ifdef EX_ALU_OVERFLOW_EN
    compared++;
    if (ovf !== 1'b0) begin
      $display("FAIL reset_overflow: overflow=%b, required 0", ovf);
      mismatched++;
    end
`endif
    rst = 1'b0;
  endtask

  task automatic test_directed;
    vec_t v[$];
    v.push_back('{ALUOP_MEM_ADDR, 3'd0, 1'b0, 32'd100, 32'd20, 32'd120});
    v.push_back('{ALUOP_BRANCH,   3'd0, 1'b0, 32'd50,  32'd50, 32'd0});
    v.push_back('{ALUOP_BRANCH,   3'd0, 1'b0, 32'd50,  32'd40, 32'd10});
    v.push_back('{ALUOP_LUI,      3'd0, 1'b0, 32'd0,   32'hABCD0000, 32'hABCD0000});
    v.push_back('{ALUOP_JUMP,     3'd0, 1'b0, 32'h1000, 32'd4, 32'h1004});
    v.push_back('{ALUOP_RTYPE, 3'd0, 1'b0, 32'd15, 32'd7, 32'd22});
    v.push_back('{ALUOP_RTYPE, 3'd0, 1'b1, 32'd15, 32'd7, 32'd8});
    v.push_back('{ALUOP_RTYPE, 3'd5, 1'b0, 32'd16, 32'd2, 32'd4});
    v.push_back('{ALUOP_RTYPE, 3'd5, 1'b1, 32'hFFFFFFF0, 32'd2, 32'hFFFFFFFC});
    v.push_back('{ALUOP_RTYPE, 3'd1, 1'b0, 32'd5, 32'd3, 32'd40});
    v.push_back('{ALUOP_RTYPE, 3'd2, 1'b0, 32'd10, 32'd20, 32'd1});
    v.push_back('{ALUOP_RTYPE, 3'd3, 1'b0, 32'd10, 32'd20, 32'd1});
    v.push_back('{ALUOP_RTYPE, 3'd4, 1'b1, 32'd5, 32'd3, 32'd6});
    v.push_back('{ALUOP_RTYPE, 3'd6, 1'b0, 32'd5, 32'd3, 32'd7});
    v.push_back('{ALUOP_RTYPE, 3'd7, 1'b1, 32'd5, 32'd3, 32'd1});
    v.push_back('{ALUOP_RTYPE, 3'd2, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd1});
    v.push_back('{ALUOP_RTYPE, 3'd3, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0});
    v.push_back('{ALUOP_RTYPE, 3'd1, 1'b0, 32'd1, 32'h25, 32'd32});
    v.push_back('{ALUOP_ITYPE_ARITH, 3'd0, 1'b1, 32'd10, 32'd5, 32'd15});
    v.push_back('{ALUOP_ITYPE_ARITH, 3'd5, 1'b0, 32'd32, 32'd3, 32'd4});
    v.push_back('{ALUOP_ITYPE_ARITH, 3'd5, 1'b1, 32'hFFFFFFE0, 32'd3, 32'hFFFFFFFC});
    v.push_back('{ALUOP_ITYPE_ARITH, 3'd1, 1'b0, 32'd6, 32'd2, 32'd24});
    v.push_back('{ALUOP_ITYPE_ARITH, 3'd2, 1'b0, 32'd10, 32'd5, 32'd0});
    v.push_back('{ALUOP_ITYPE_ARITH, 3'd3, 1'b0, 32'd5, 32'd10, 32'd1});
    v.push_back('{ALUOP_ITYPE_ARITH, 3'd4, 1'b0, 32'd7, 32'd2, 32'd5});
    v.push_back('{ALUOP_ITYPE_ARITH, 3'd6, 1'b0, 32'd6, 32'd1, 32'd7});
    v.push_back('{ALUOP_ITYPE_ARITH, 3'd7, 1'b0, 32'd7, 32'd3, 32'd3});
    v.push_back('{ALUOP_NONE,        3'd0, 1'b0, 32'd7, 32'd3, 32'd0});
    foreach (v[i]) begin
      drive(v[i].op, v[i].f3, v[i].f7, v[i].a, v[i].b);
      @(posedge clk);
      #1;
      compared++;
      if (res !== v[i].exp || zf !== (v[i].exp == 32'd0)) begin
        $display("FAIL directed_%0d: result=%h zero=%b, required result=%h zero=%b",
                 i, res, zf, v[i].exp, (v[i].exp == 32'd0));
        mismatched++;
      end
    end
  endtask

  task automatic test_x_funct;
    alu_op_e ops[5] = '{ALUOP_NONE, ALUOP_MEM_ADDR, ALUOP_BRANCH, ALUOP_LUI, ALUOP_JUMP};
    logic [31:0] a, b, e;
    foreach (ops[i]) begin
      a = $urandom; b = $urandom;
      drive(ops[i], 3'bxxx, 1'bx, a, b);
      e = ref_result(ref_kind(ops[i], 3'd0, 1'b0), a, b);
      @(posedge clk);
      #1;
      compared++;
      if ($isunknown({res, zf}) || res !== e || zf !== (e == 32'd0)) begin
        $display("FAIL x_funct_%0d: result=%h zero=%b, required result=%h zero=%b",
                 i, res, zf, e, (e == 32'd0));
        mismatched++;
      end
    end
  endtask

  task automatic test_latency;
    drive(ALUOP_MEM_ADDR, 3'd0, 1'b0, 32'd3, 32'd4);
    @(posedge clk);
    #1;
    drive(ALUOP_MEM_ADDR, 3'd0, 1'b0, 32'd100, 32'd200);
    #3;
    compared++;
    if (res !== 32'd7) begin
      $display("FAIL latency_hold: result=%h before edge, required %h", res, 32'd7);
      mismatched++;
    end
    @(posedge clk);
    #1;
    compared++;
    if (res !== 32'd300) begin
      $display("FAIL latency_update: result=%h after edge, required %h", res, 32'd300);
      mismatched++;
    end
  endtask

  task automatic test_reset_midstream;
    drive(ALUOP_MEM_ADDR, 3'd0, 1'b0, 32'd1, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    compared++;
    if (res !== 32'd0 || zf !== 1'b1) begin
      $display("FAIL reset_midstream: result=%h zero=%b, required result=0 zero=1", res, zf);
      mismatched++;
    end
    @(posedge clk);
    #1;
    compared++;
    if (res !== 32'd2 || zf !== 1'b0) begin
      $display("FAIL after_reset: result=%h zero=%b, required result=2 zero=0", res, zf);
      mismatched++;
    end
  endtask

  task automatic test_illegal_op;
    drive(alu_op_e'(3'd7), 3'd0, 1'b0, 32'd12, 32'd34);
    @(posedge clk);
    #1;
    compared++;
    if (res !== 32'd0 || zf !== 1'b1) begin
      $display("FAIL illegal_op: result=%h zero=%b, required result=0 zero=1", res, zf);
      mismatched++;
    end
  endtask

  task automatic test_random;
    logic [2:0]  o, x3;
    logic        x7;
    logic [31:0] a, b, e;
    int          k;
    for (int n = 0; n < 400; n++) begin
      o = 3'($urandom_range(0, 7));
      x3 = 3'($urandom); x7 = 1'($urandom);
      a = $urandom; b = $urandom;
      if (n % 5 == 0) b = 32'($urandom_range(0, 40));
      if (n % 7 == 0) a = b;
      drive(alu_op_e'(o), x3, x7, a, b);
      k = ref_kind(o, x3, x7);
      e = ref_result(k, a, b);
      @(posedge clk);
      #1;
      compared++;
      if (res !== e || zf !== (e == 32'd0)) begin
        $display("FAIL random_%0d: op=%0d f3=%0d f7=%b a=%h b=%h result=%h zero=%b, required result=%h zero=%b",
                 n, o, x3, x7, a, b, res, zf, e, (e == 32'd0));
        mismatched++;
      end
`ifdef EX_ALU_OVERFLOW_EN
      compared++;
      if (ovf !== ref_overflow(k, a, b)) begin
        $display("FAIL random_ovf_%0d: overflow=%b, required %b", n, ovf, ref_overflow(k, a, b));
        mismatched++;
      end
`else
      if (ref_overflow(k, a, b) === 1'bx) mismatched++;
`endif
    end
  endtask

`ifdef EX_ALU_OVERFLOW_EN
  task automatic test_overflow;
    drive(ALUOP_MEM_ADDR, 3'd0, 1'b0, 32'h7FFFFFFF, 32'd1);
    @(posedge clk);
    #1;
    compared++;
    if (res !== 32'h80000000 || ovf !== 1'b1) begin
      $display("FAIL ovf_add: result=%h overflow=%b, required result=80000000 overflow=1", res, ovf);
      mismatched++;
    end
    drive(ALUOP_BRANCH, 3'd0, 1'b0, 32'h80000000, 32'd1);
    @(posedge clk);
    #1;
    compared++;
    if (ovf !== 1'b1) begin
      $display("FAIL ovf_sub: overflow=%b, required 1", ovf);
      mismatched++;
    end
    drive(ALUOP_RTYPE, 3'd7, 1'b0, 32'h7FFFFFFF, 32'hFFFFFFFF);
    @(posedge clk);
    #1;
    compared++;
    if (ovf !== 1'b0) begin
      $display("FAIL ovf_and: overflow=%b, required 0", ovf);
      mismatched++;
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    drive(ALUOP_NONE, 3'd0, 1'b0, 32'd0, 32'd0);
    #1;
    test_reset;
    test_directed;
    test_x_funct;
    test_latency;
    test_reset_midstream;
    test_illegal_op;
`ifdef EX_ALU_OVERFLOW_EN
    test_overflow;
`endif
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
